// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: entry layout, forwarding
// constant and elaboration-time parameter legality check.
package hazard_pkg;

    // Register fields are stored at this width; narrower REG_AW values are zero-extended.
    localparam int unsigned MaxRegAw = 8;

    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [MaxRegAw-1:0] wr_reg;
        logic                is_load;
        logic [MaxRegAw-1:0] rs;
        logic [MaxRegAw-1:0] rt;
        logic                use_rs;
        logic                use_rt;
    } sb_entry_t;

    function automatic bit params_ok(int unsigned reg_aw, int unsigned depth,
                                     int unsigned load_lat, int unsigned br_stage);
        return (reg_aw >= 1) && (reg_aw <= MaxRegAw) &&
               (depth >= 2) && (depth <= 8) &&
               (load_lat >= 1) && (load_lat + 2 <= depth) &&
               (br_stage < depth);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-writer priority finder: lowest entry index in [FIRST, LAST] that
// writes src (register 0 never matches).
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned FIRST = 0,
    parameter int unsigned LAST  = DEPTH - 1,
    parameter int unsigned SEL_W = $clog2(DEPTH)
) (
    input  logic [MaxRegAw-1:0]   src,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic                  hit,
    output logic [SEL_W-1:0]      idx,
    output logic                  is_load
);

    logic unused_entry_bits;
    assign unused_entry_bits = ^entries;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        if (src != '0) begin
            for (int k = int'(LAST); k >= int'(FIRST); k--) begin
                if (entries[k].valid && entries[k].wr_en && entries[k].wr_reg == src) begin
                    hit     = 1'b1;
                    idx     = SEL_W'(k);
                    is_load = entries[k].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection / forwarding controller with a shift-register scoreboard.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_STAGE = 1,
    parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              br_taken,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel
);

    localparam bit ParamsOk = params_ok(REG_AW, DEPTH, LOAD_LAT, BR_STAGE);

    if (!ParamsOk) begin : g_param_err
        $error("hazard_scoreboard: illegal parameter combination");
    end

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    sb_entry_t             id_ent;

    logic             ex_rs_hit, ex_rt_hit, id_rs_hit, id_rt_hit;
    logic             ex_rs_ld, ex_rt_ld, id_rs_ld, id_rt_ld;
    logic [SEL_W-1:0] ex_rs_idx, ex_rt_idx, id_rs_idx, id_rt_idx;
    logic             stall, rs_stall, rt_stall;
    logic             unused_ex_ld;

    assign unused_ex_ld = ex_rs_ld ^ ex_rt_ld;

    always_comb begin
        id_ent                    = '0;
        id_ent.valid              = 1'b1;
        id_ent.wr_en              = id_wr_en;
        id_ent.wr_reg[REG_AW-1:0] = id_wr_reg;
        id_ent.is_load            = id_is_load;
        id_ent.rs[REG_AW-1:0]     = id_rs;
        id_ent.rt[REG_AW-1:0]     = id_rt;
        id_ent.use_rs             = id_use_rs;
        id_ent.use_rt             = id_use_rt;
    end

    // EX forwarding searches older entries only; entry 0 is the consumer itself.
    hazard_match #(.DEPTH(DEPTH), .FIRST(1), .LAST(DEPTH - 1), .SEL_W(SEL_W)) u_ex_rs (
        .src(sb_q[0].rs), .entries(sb_q), .hit(ex_rs_hit), .idx(ex_rs_idx), .is_load(ex_rs_ld)
    );
    hazard_match #(.DEPTH(DEPTH), .FIRST(1), .LAST(DEPTH - 1), .SEL_W(SEL_W)) u_ex_rt (
        .src(sb_q[0].rt), .entries(sb_q), .hit(ex_rt_hit), .idx(ex_rt_idx), .is_load(ex_rt_ld)
    );
    // The last entry writes the register file before ID reads it, so it is excluded.
    hazard_match #(.DEPTH(DEPTH), .FIRST(0), .LAST(DEPTH - 2), .SEL_W(SEL_W)) u_id_rs (
        .src(id_ent.rs), .entries(sb_q), .hit(id_rs_hit), .idx(id_rs_idx), .is_load(id_rs_ld)
    );
    hazard_match #(.DEPTH(DEPTH), .FIRST(0), .LAST(DEPTH - 2), .SEL_W(SEL_W)) u_id_rt (
        .src(id_ent.rt), .entries(sb_q), .hit(id_rt_hit), .idx(id_rt_idx), .is_load(id_rt_ld)
    );

    assign rs_stall = id_use_rs && id_rs_hit && id_rs_ld && (32'(id_rs_idx) < LOAD_LAT);
    assign rt_stall = id_use_rt && id_rt_hit && id_rt_ld && (32'(id_rt_idx) < LOAD_LAT);
    assign stall    = id_valid && (rs_stall || rt_stall);

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        fwd_a_sel = SEL_W'(FWD_RF);
        fwd_b_sel = SEL_W'(FWD_RF);
        if (!RESET) begin
            stall_f = stall && !br_taken;
            stall_d = stall && !br_taken;
            flush_d = br_taken;
            flush_e = stall || br_taken;
            if (sb_q[0].use_rs && ex_rs_hit) fwd_a_sel = ex_rs_idx;
            if (sb_q[0].use_rt && ex_rt_hit) fwd_b_sel = ex_rt_idx;
        end
    end

    // Instructions younger than the resolving branch are squashed as they shift.
    always_comb begin
        sb_d = '0;
        for (int k = 1; k < int'(DEPTH); k++) begin
            sb_d[k] = (br_taken && k <= int'(BR_STAGE)) ? '0 : sb_q[k-1];
        end
        if (id_valid && !stall && !br_taken) sb_d[0] = id_ent;
    end

    always_ff @(posedge CLK) begin
        if (RESET) sb_q <= '0;
        else       sb_q <= sb_d;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
